// File: rtl/apple_bus_capture_pkg.sv
// Shared types, default sample offsets and the bitwise majority voter for the bus capture block.
package apple_bus_capture_pkg;

   // Offsets that suit a 54 MHz logic clock against a 1.02 MHz bus clock.
   localparam int unsigned DefAddrCount = 18;
   localparam int unsigned DefDataCount = 15;

   // Widest data bus the voter handles; narrower buses are zero-extended into it.
   localparam int unsigned VoteWidth = 64;

   // Record layout for the default 16-bit address / 8-bit data geometry.
   typedef struct packed {
      logic        rw_n;
      logic [15:0] addr;
      logic [7:0]  data;
   } bus_rec_t;

   function automatic logic [VoteWidth-1:0] majority3(input logic [VoteWidth-1:0] a,
                                                      input logic [VoteWidth-1:0] b,
                                                      input logic [VoteWidth-1:0] c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/apple_bus_capture_if.sv
// Record drain port: valid/ready handshake plus head record and FIFO occupancy.
interface apple_bus_capture_if #(
   parameter int unsigned REC_WIDTH   = 25,
   parameter int unsigned COUNT_WIDTH = 4
);
   logic                   rec_valid;
   logic                   rec_ready;
   logic [REC_WIDTH-1:0]   rec;
   logic [COUNT_WIDTH-1:0] rec_count;

   modport master (output rec_valid, output rec, output rec_count, input rec_ready);
   modport slave  (input rec_valid, input rec, input rec_count, output rec_ready);
endinterface

// File: rtl/apple_bus_capture_fifo.sv
// Synchronous record FIFO; push and pop may coincide at any occupancy, including full.
module apple_bus_capture_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 25,
   localparam int unsigned PtrW   = $clog2(DEPTH),
   localparam int unsigned CountW = PtrW + 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              push_i,
   input  logic [WIDTH-1:0]  push_data_i,
   input  logic              pop_i,
   output logic [WIDTH-1:0]  head_o,
   output logic              valid_o,
   output logic [CountW-1:0] count_o,
   output logic              drop_o
);
   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CountW-1:0] count_q;
   logic              empty, full, do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CountW'(DEPTH));
   assign do_pop  = pop_i && !empty;
   // A pop in the same cycle frees the slot the push lands in.
   assign do_push = push_i && (!full || do_pop);
   assign drop_o  = push_i && full && !do_pop;

   assign head_o  = mem_q[rd_ptr_q];
   assign valid_o = !empty;
   assign count_o = count_q;

   // Storage array; no reset needed since occupancy gates visibility.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (do_push && !do_pop) begin
            count_q <= count_q + 1'b1;
         end else if (do_pop && !do_push) begin
            count_q <= count_q - 1'b1;
         end
      end
   end
endmodule

// File: rtl/apple_bus_capture.sv
// Apple II bus sampler: phase counter, address/data sampling, optional data vote, record FIFO.
module apple_bus_capture
   import apple_bus_capture_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = 16,
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned CNT_WIDTH    = 6,
   parameter int unsigned DATA_SAMPLES = 1,
   parameter int unsigned LATCH_READS  = 0,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic                  clk_logic_i,
   input  logic                  system_reset_i,
   input  logic                  phi1_i,
   input  logic                  phi1_posedge_i,
   input  logic                  phi1_negedge_i,
   input  logic [ADDR_WIDTH-1:0] a2_a_i,
   input  logic [DATA_WIDTH-1:0] a2_d_i,
   input  logic                  a2_rw_n_i,
   input  logic [CNT_WIDTH-1:0]  cfg_addr_count_i,
   input  logic [CNT_WIDTH-1:0]  cfg_data_count_i,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic                  rw_n_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  addr_strobe_o,
   output logic                  data_strobe_o,
   apple_bus_capture_if.master   rec_if,
   output logic                  overflow_o,
   input  logic                  clear_overflow_i,
   output logic                  cycle_miss_o,
   output logic                  sleep_o
);
   localparam int unsigned RecW   = 1 + ADDR_WIDTH + DATA_WIDTH;
   localparam int unsigned CountW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_WIDTH:0] LastOfs = (CNT_WIDTH + 1)'(DATA_SAMPLES - 1);
   localparam logic [CNT_WIDTH:0] CntMax  = {1'b0, {CNT_WIDTH{1'b1}}};

   logic [CNT_WIDTH-1:0]  cnt_q, addr_cfg_q, data_cfg_q, k_idx;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] data_q, sample0_q, sample1_q, voted;
   logic                  rw_n_q, addr_strobe_q, data_strobe_q, cycle_miss_q, overflow_q;
   logic                  addr_seen_q, data_pend_q;
   logic                  edge_strobe, cnt_max, addr_hit, data_hit, data_final, abort, push;
   logic [CNT_WIDTH:0]    cnt_ext, data_start, data_end;
   logic                  fifo_drop;

   assign edge_strobe = phi1_posedge_i | phi1_negedge_i;
   assign cnt_max     = (cnt_q == '1);
   assign cnt_ext     = {1'b0, cnt_q};
   assign data_start  = {1'b0, data_cfg_q};
   assign data_end    = data_start + LastOfs;
   assign k_idx       = cnt_q - data_cfg_q;

   // The edge-strobe cycle still carries the previous phase's count, so it never samples.
   // A saturated counter never matches either, which keeps a stalled bus from re-latching.
   assign addr_hit   = phi1_i && !edge_strobe && !cnt_max && (cnt_q == addr_cfg_q);
   // Windows ending at or past all-ones are unreachable and fall through to the abort path.
   assign data_hit   = data_pend_q && !phi1_i && !edge_strobe && (data_end < CntMax) &&
                       (cnt_ext >= data_start) && (cnt_ext <= data_end);
   assign data_final = data_hit && (cnt_ext == data_end);
   assign abort      = edge_strobe && data_pend_q;
   assign push       = data_final && addr_seen_q;

   // The last sample is taken straight from the bus in the final cycle.
   assign voted = (DATA_SAMPLES == 3)
                  ? DATA_WIDTH'(majority3(VoteWidth'(sample0_q), VoteWidth'(sample1_q),
                                          VoteWidth'(a2_d_i)))
                  : a2_d_i;

   // Phase counter: restarts on every phi1 edge, saturates when the bus clock stops.
   always_ff @(posedge clk_logic_i or posedge system_reset_i) begin
      if (system_reset_i) begin
         cnt_q <= '1;
      end else if (edge_strobe) begin
         cnt_q <= '0;
      end else if (!cnt_max) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Offsets are taken once per bus cycle so a mid-cycle change cannot split a cycle.
   always_ff @(posedge clk_logic_i or posedge system_reset_i) begin
      if (system_reset_i) begin
         addr_cfg_q <= CNT_WIDTH'(DefAddrCount);
         data_cfg_q <= CNT_WIDTH'(DefDataCount);
      end else if (phi1_posedge_i) begin
         addr_cfg_q <= cfg_addr_count_i;
         data_cfg_q <= cfg_data_count_i;
      end
   end

   // Address/RW capture in phi1.
   always_ff @(posedge clk_logic_i or posedge system_reset_i) begin
      if (system_reset_i) begin
         addr_q        <= '0;
         rw_n_q        <= 1'b1;
         addr_strobe_q <= 1'b0;
      end else begin
         addr_strobe_q <= addr_hit;
         if (addr_hit) begin
            addr_q <= a2_a_i;
            rw_n_q <= a2_rw_n_i;
         end
      end
   end

   // Data sampling, completion and abort tracking across the phi0 window.
   always_ff @(posedge clk_logic_i or posedge system_reset_i) begin
      if (system_reset_i) begin
         data_q        <= '0;
         sample0_q     <= '0;
         sample1_q     <= '0;
         data_strobe_q <= 1'b0;
         cycle_miss_q  <= 1'b0;
         addr_seen_q   <= 1'b0;
         data_pend_q   <= 1'b0;
      end else begin
         data_strobe_q <= data_final;
         cycle_miss_q  <= abort || (data_final && !addr_seen_q);

         if (addr_hit) begin
            addr_seen_q <= 1'b1;
         end else if (abort || data_final) begin
            addr_seen_q <= 1'b0;
         end

         // A negedge arms a new data window; any edge also ends the one in flight.
         if (phi1_negedge_i) begin
            data_pend_q <= 1'b1;
         end else if (phi1_posedge_i || data_final) begin
            data_pend_q <= 1'b0;
         end

         if (abort) begin
            sample0_q <= '0;
            sample1_q <= '0;
         end else if (data_hit && !data_final) begin
            if (k_idx == '0)                sample0_q <= a2_d_i;
            if (k_idx == CNT_WIDTH'(1))     sample1_q <= a2_d_i;
         end

         if (data_final && (!rw_n_q || (LATCH_READS != 0))) begin
            data_q <= voted;
         end
      end
   end

   // Sticky overflow; a drop in the same cycle as a clear keeps it set.
   always_ff @(posedge clk_logic_i or posedge system_reset_i) begin
      if (system_reset_i) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= (overflow_q && !clear_overflow_i) || fifo_drop;
      end
   end

   apple_bus_capture_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (RecW)
   ) u_fifo (
      .clk_i       (clk_logic_i),
      .rst_i       (system_reset_i),
      .push_i      (push),
      .push_data_i ({rw_n_q, addr_q, voted}),
      .pop_i       (rec_if.rec_ready),
      .head_o      (rec_if.rec),
      .valid_o     (rec_if.rec_valid),
      .count_o     (rec_if.rec_count),
      .drop_o      (fifo_drop)
   );

   assign addr_o        = addr_q;
   assign rw_n_o        = rw_n_q;
   assign data_o        = data_q;
   assign addr_strobe_o = addr_strobe_q;
   assign data_strobe_o = data_strobe_q;
   assign overflow_o    = overflow_q;
   assign cycle_miss_o  = cycle_miss_q;
   assign sleep_o       = cnt_max;

endmodule

// File: tb/tb_apple_bus_capture.sv
// Directed bench: three instances (default, LATCH_READS=1, DATA_SAMPLES=3) on one shared bus.
module tb_apple_bus_capture;
   localparam int unsigned RecW = 25;
   localparam int unsigned CntW = 4;

   logic        clk = 1'b0;
   logic        rst, phi1, phi1_pos, phi1_neg, rw_n, rec_ready, clr_ovf;
   logic [15:0] a;
   logic [7:0]  d;
   logic [5:0]  cfg_a, cfg_d;

   logic [15:0]     addr_w  [3];
   logic [7:0]      data_w  [3];
   logic [RecW-1:0] rec_w   [3];
   logic [CntW-1:0] count_w [3];
   logic            rw_w [3], astb_w [3], dstb_w [3], valid_w [3];
   logic            ovf_w [3], miss_w [3], sleep_w [3];

   int nvec = 0;
   int nmis = 0;
   int addr_stb_at, dstb0_at, dstb2_at, miss_n, ready_at;
   logic hold_ready;
   logic [7:0] dq0, dq1, dq2;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      apple_bus_capture_if #(.REC_WIDTH(RecW), .COUNT_WIDTH(CntW)) rif ();
      assign rif.rec_ready = rec_ready;
      assign rec_w[g]      = rif.rec;
      assign count_w[g]    = rif.rec_count;
      assign valid_w[g]    = rif.rec_valid;

      apple_bus_capture #(
         .DATA_SAMPLES ((g == 2) ? 3 : 1),
         .LATCH_READS  ((g == 1) ? 1 : 0),
         .FIFO_DEPTH   (8)
      ) u_dut (
         .clk_logic_i      (clk),
         .system_reset_i   (rst),
         .phi1_i           (phi1),
         .phi1_posedge_i   (phi1_pos),
         .phi1_negedge_i   (phi1_neg),
         .a2_a_i           (a),
         .a2_d_i           (d),
         .a2_rw_n_i        (rw_n),
         .cfg_addr_count_i (cfg_a),
         .cfg_data_count_i (cfg_d),
         .addr_o           (addr_w[g]),
         .rw_n_o           (rw_w[g]),
         .data_o           (data_w[g]),
         .addr_strobe_o    (astb_w[g]),
         .data_strobe_o    (dstb_w[g]),
         .rec_if           (rif.master),
         .overflow_o       (ovf_w[g]),
         .clear_overflow_i (clr_ovf),
         .cycle_miss_o     (miss_w[g]),
         .sleep_o          (sleep_w[g])
      );
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nmis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_mon();
      addr_stb_at = -1;
      dstb0_at    = -1;
      dstb2_at    = -1;
      miss_n      = 0;
   endtask

   // One bus phase; after each edge the outputs belong to phase cycle i+1 (count = i).
   task automatic run_phase(input logic phi, input int len);
      for (int i = 0; i < len; i++) begin
         phi1     = phi;
         phi1_pos = phi && (i == 0);
         phi1_neg = !phi && (i == 0);
         if (!phi) d = (i == 16) ? dq0 : (i == 17) ? dq1 : (i == 18) ? dq2 : 8'h00;
         rec_ready = hold_ready || (!phi && (i == ready_at));
         tick();
         if (astb_w[0] && addr_stb_at < 0) addr_stb_at = i;
         if (dstb_w[0] && dstb0_at < 0)    dstb0_at = i;
         if (dstb_w[2] && dstb2_at < 0)    dstb2_at = i;
         if (miss_w[0])                    miss_n++;
      end
      phi1_pos  = 1'b0;
      phi1_neg  = 1'b0;
      rec_ready = hold_ready;
   endtask

   task automatic bus_cycle(input logic r, input logic [15:0] ad, input logic [7:0] b0,
                            input logic [7:0] b1, input logic [7:0] b2);
      clr_mon();
      rw_n = r;
      a    = ad;
      dq0  = b0;
      dq1  = b1;
      dq2  = b2;
      run_phase(1'b1, 26);
      run_phase(1'b0, 26);
   endtask

   task automatic drain();
      hold_ready = 1'b1;
      rec_ready  = 1'b1;
      repeat (10) tick();
      hold_ready = 1'b0;
      rec_ready  = 1'b0;
   endtask

   initial begin
      rst = 1'b1; phi1 = 1'b0; phi1_pos = 1'b0; phi1_neg = 1'b0; rw_n = 1'b1;
      rec_ready = 1'b0; clr_ovf = 1'b0; a = '0; d = '0; cfg_a = 6'd18; cfg_d = 6'd15;
      hold_ready = 1'b0; ready_at = -1; dq0 = '0; dq1 = '0; dq2 = '0;
      clr_mon();
      repeat (3) tick();
      check("rst_sleep", 32'(sleep_w[0]), 32'd1);
      check("rst_addr",  32'(addr_w[0]),  32'd0);
      check("rst_rw_n",  32'(rw_w[0]),    32'd1);
      check("rst_data",  32'(data_w[0]),  32'd0);
      check("rst_count", 32'(count_w[0]), 32'd0);
      check("rst_valid", 32'(valid_w[0]), 32'd0);
      check("rst_ovf",   32'(ovf_w[0]),   32'd0);
      check("rst_astb",  32'(astb_w[0]),  32'd0);
      check("rst_dstb",  32'(dstb_w[0]),  32'd0);
      check("rst_miss",  32'(miss_w[0]),  32'd0);
      rst = 1'b0;
      tick();

      // Write $C0A5 = $3C
      bus_cycle(1'b0, 16'hC0A5, 8'h3C, 8'h3C, 8'h3C);
      check("w_astb_cnt", 32'(addr_stb_at), 32'd19);
      check("w_dstb_cnt", 32'(dstb0_at),    32'd16);
      check("w_data",     32'(data_w[0]),   32'h3C);
      check("w_addr",     32'(addr_w[0]),   32'hC0A5);
      check("w_rw_n",     32'(rw_w[0]),     32'd0);
      check("w_rec",      32'(rec_w[0]),    32'h00C0A53C);
      check("w_count",    32'(count_w[0]),  32'd1);
      check("w_valid",    32'(valid_w[0]),  32'd1);
      check("w_miss",     32'(miss_n),      32'd0);
      check("w_sleep",    32'(sleep_w[0]),  32'd0);
      drain();
      check("drain_count", 32'(count_w[0]), 32'd0);

      // Read $C0B0 -> $77
      bus_cycle(1'b1, 16'hC0B0, 8'h77, 8'h77, 8'h77);
      check("r_data_hold", 32'(data_w[0]), 32'h3C);
      check("r_data_latch", 32'(data_w[1]), 32'h77);
      check("r_rec",       32'(rec_w[0]),  32'h01C0B077);
      check("r_rw_n",      32'(rw_w[0]),   32'd1);
      drain();

      // Majority vote on three consecutive samples
      bus_cycle(1'b0, 16'h1234, 8'hF0, 8'h0F, 8'hF0);
      check("v1_data3",   32'(data_w[2]), 32'hF0);
      check("v1_dstb_cnt", 32'(dstb2_at), 32'd18);
      bus_cycle(1'b0, 16'h1235, 8'h0F, 8'hF0, 8'hF0);
      check("v2_data3", 32'(data_w[2]), 32'hF0);
      check("v2_data1", 32'(data_w[0]), 32'h0F);
      bus_cycle(1'b0, 16'h1236, 8'hA5, 8'h5A, 8'h00);
      check("v3_data3", 32'(data_w[2]), 32'h00);
      check("v3_rec3_head", 32'(rec_w[2]), 32'h001234F0);
      check("v3_count3", 32'(count_w[2]), 32'd3);
      drain();

      // Nine writes into an 8-deep FIFO with no consumer
      for (int i = 0; i < 9; i++) begin
         bus_cycle(1'b0, 16'h0100 + 16'(i), 8'h10 + 8'(i), 8'h10 + 8'(i), 8'h10 + 8'(i));
      end
      check("ovf_count", 32'(count_w[0]), 32'd8);
      check("ovf_flag",  32'(ovf_w[0]),   32'd1);
      check("ovf_head",  32'(rec_w[0]),   32'h00010010);
      check("ovf_data",  32'(data_w[0]),  32'h18);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      check("ovf_clear", 32'(ovf_w[0]), 32'd0);

      // Push and pop together while full
      ready_at = 16;
      bus_cycle(1'b0, 16'h0200, 8'h55, 8'h55, 8'h55);
      ready_at = -1;
      check("full_pp_count", 32'(count_w[0]), 32'd8);
      check("full_pp_ovf",   32'(ovf_w[0]),   32'd0);
      check("full_pp_head",  32'(rec_w[0]),   32'h00010111);
      drain();
      check("empty_count", 32'(count_w[0]), 32'd0);
      check("empty_valid", 32'(valid_w[0]), 32'd0);

      // phi1 edge arrives at phi0 count 10, before the data offset
      clr_mon();
      rw_n = 1'b0; a = 16'h2222; dq0 = 8'hAA; dq1 = 8'hAA; dq2 = 8'hAA;
      run_phase(1'b1, 26);
      run_phase(1'b0, 11);
      run_phase(1'b1, 26);
      check("abort_miss",  32'(miss_n),      32'd1);
      check("abort_count", 32'(count_w[0]),  32'd0);
      check("abort_data",  32'(data_w[0]),   32'h55);
      clr_mon();
      run_phase(1'b0, 26);
      check("resume_count", 32'(count_w[0]), 32'd1);
      check("resume_rec",   32'(rec_w[0]),   32'h002222AA);
      check("resume_miss",  32'(miss_n),     32'd0);

      // Bus clock stops: counter is at 25 here, saturates 38 clocks later
      repeat (37) tick();
      check("sleep_before", 32'(sleep_w[0]), 32'd0);
      tick();
      check("sleep_after",  32'(sleep_w[0]), 32'd1);
      drain();

      // Reset in the middle of phi0 with three records queued
      for (int i = 0; i < 3; i++) begin
         bus_cycle(1'b0, 16'h3000 + 16'(i), 8'h01 + 8'(i), 8'h01 + 8'(i), 8'h01 + 8'(i));
      end
      check("queued_count", 32'(count_w[0]), 32'd3);
      clr_mon();
      rw_n = 1'b0; a = 16'h4000;
      run_phase(1'b1, 26);
      run_phase(1'b0, 10);
      rst = 1'b1;
      #1;
      check("mrst_count", 32'(count_w[0]), 32'd0);
      check("mrst_valid", 32'(valid_w[0]), 32'd0);
      check("mrst_sleep", 32'(sleep_w[0]), 32'd1);
      check("mrst_addr",  32'(addr_w[0]),  32'd0);
      tick();
      rst = 1'b0;

      // A lone phi0 after reset has no address, so it is a miss
      clr_mon();
      rw_n = 1'b0; a = 16'h5000; dq0 = 8'h66; dq1 = 8'h66; dq2 = 8'h66;
      run_phase(1'b0, 26);
      check("post_rst_miss",  32'(miss_n),     32'd1);
      check("post_rst_count", 32'(count_w[0]), 32'd0);
      bus_cycle(1'b0, 16'h4444, 8'h77, 8'h77, 8'h77);
      check("post_rst_rec",   32'(rec_w[0]),   32'h00444477);
      check("post_rst_cnt1",  32'(count_w[0]), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
